// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usr_pkg
// Description : Shared types for the universal shift register: per-step
//               operation codes and burst controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

    // Operation codes, one step = LANES bit positions
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    // Burst controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : usr_pkg
`default_nettype wire

// File: rtl/universal_shift_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_reg_if
// Description : Control/data bundle of the universal shift register. The
//               master side drives mode/strobes/data, the slave side returns
//               register contents, serial lanes and burst status.
// Revision    : 1.0 - initial release
// ============================================================================
interface universal_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
);
    localparam int CW = $clog2(WIDTH / LANES) + 1;

    logic [2:0]       mode;
    logic             en;
    logic             start;
    logic [CW-1:0]    cnt_in;
    logic [WIDTH-1:0] par_in;
    logic [LANES-1:0] ser_in;
    logic [WIDTH-1:0] par_out;
    logic [LANES-1:0] ser_out;
    logic             busy;
    logic             done;

    modport master (
        output mode, en, start, cnt_in, par_in, ser_in,
        input  par_out, ser_out, busy, done
    );

    modport slave (
        input  mode, en, start, cnt_in, par_in, ser_in,
        output par_out, ser_out, busy, done
    );

endinterface : universal_shift_reg_if
`default_nettype wire

// File: rtl/usr_step.sv
`default_nettype none
// ============================================================================
// Module      : usr_step
// Description : Combinational next-state of one shift-register step. Shared
//               by the single-operation path and the burst path.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  mode_e            i_mode,
    input  logic [WIDTH-1:0] i_cur,
    input  logic [LANES-1:0] i_ser_in,
    input  logic [WIDTH-1:0] i_par_in,
    output logic [WIDTH-1:0] o_nxt,
    output logic [LANES-1:0] o_ser_nxt
);

    // Shift operators are used instead of part-selects so LANES == WIDTH
    // still elaborates without zero-width slices.
    always_comb begin
        o_nxt     = i_cur;
        o_ser_nxt = '0;
        unique case (i_mode)
            MODE_HOLD: ;
            MODE_SHL: begin
                o_nxt     = (i_cur << LANES) | WIDTH'(i_ser_in);
                o_ser_nxt = i_cur[WIDTH-1 -: LANES];
            end
            MODE_SHR: begin
                o_nxt     = (i_cur >> LANES) | (WIDTH'(i_ser_in) << (WIDTH - LANES));
                o_ser_nxt = i_cur[LANES-1:0];
            end
            MODE_LOAD: o_nxt = i_par_in;
            MODE_ROL: begin
                o_nxt     = (i_cur << LANES) | (i_cur >> (WIDTH - LANES));
                o_ser_nxt = i_cur[WIDTH-1 -: LANES];
            end
            MODE_ROR: begin
                o_nxt     = (i_cur >> LANES) | (i_cur << (WIDTH - LANES));
                o_ser_nxt = i_cur[LANES-1:0];
            end
            MODE_ASR: begin
                o_nxt     = WIDTH'($signed(i_cur) >>> LANES);
                o_ser_nxt = i_cur[LANES-1:0];
            end
            MODE_CLR: o_nxt = '0;
            default: ;
        endcase
    end

endmodule : usr_step
`default_nettype wire

// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_reg
// Description : Parametrised universal shift register with LANES-bit serial
//               lanes, single-step operation and a counted burst controller
//               reporting busy/done.
// Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    universal_shift_reg_if.slave bus
);

    localparam int CW = $clog2(WIDTH / LANES) + 1;

    if ((WIDTH < 2) || (LANES < 1) || ((WIDTH % LANES) != 0)) begin : g_param_check
        $error("universal_shift_reg: WIDTH must be >= 2 and divisible by LANES");
    end

    state_e           r_state;
    mode_e            r_mode;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_par;
    logic [LANES-1:0] r_ser;
    logic             r_busy;
    logic             r_done;

    mode_e            w_step_mode;
    logic [WIDTH-1:0] w_nxt;
    logic [LANES-1:0] w_ser_nxt;

    // A running burst replays its latched mode; otherwise the live mode applies
    assign w_step_mode = (r_state == RUN) ? r_mode : mode_e'(bus.mode);

    usr_step #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_step (
        .i_mode    (w_step_mode),
        .i_cur     (r_par),
        .i_ser_in  (bus.ser_in),
        .i_par_in  (bus.par_in),
        .o_nxt     (w_nxt),
        .o_ser_nxt (w_ser_nxt)
    );

    // Burst FSM, step counter and data registers; busy/done are flopped
    // alongside the state so every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mode  <= MODE_HOLD;
            r_cnt   <= '0;
            r_par   <= '0;
            r_ser   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        // start outranks en: latch and defer the first step
                        r_mode <= mode_e'(bus.mode);
                        r_cnt  <= bus.cnt_in;
                        if (bus.cnt_in != '0) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (bus.en) begin
                        r_par <= w_nxt;
                        r_ser <= w_ser_nxt;
                    end
                end
                RUN: begin
                    r_par <= w_nxt;
                    r_ser <= w_ser_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.par_out = r_par;
    assign bus.ser_out = r_ser;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule : universal_shift_reg
`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_universal_shift_reg
// Description : Self-checking bench driving a LANES=1 and a LANES=2 instance
//               (WIDTH=8) with directed and random stimulus, compared every
//               cycle against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int t_mode  = 0;
    int t_en    = 0;
    int t_start = 0;
    int t_cnt   = 0;
    int t_par   = 0;
    int t_ser   = 0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, index 0 = LANES 1, index 1 = LANES 2
    int m_par [2];
    int m_ser [2];
    int m_left[2];
    int m_mode[2];
    bit m_burst[2];
    bit m_done [2];

    universal_shift_reg_if #(.WIDTH(8), .LANES(1)) bus1 ();
    universal_shift_reg_if #(.WIDTH(8), .LANES(2)) bus2 ();

    universal_shift_reg #(.WIDTH(8), .LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    universal_shift_reg #(.WIDTH(8), .LANES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus1.mode   = 3'(t_mode);
    assign bus1.en     = 1'(t_en);
    assign bus1.start  = 1'(t_start);
    assign bus1.cnt_in = 4'(t_cnt);
    assign bus1.par_in = 8'(t_par);
    assign bus1.ser_in = 1'(t_ser);
    assign bus2.mode   = 3'(t_mode);
    assign bus2.en     = 1'(t_en);
    assign bus2.start  = 1'(t_start);
    assign bus2.cnt_in = 3'(t_cnt);
    assign bus2.par_in = 8'(t_par);
    assign bus2.ser_in = 2'(t_ser);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One step on an 8-bit value treated as an integer in 0..255
    task automatic model_step(input int lanes, input int md, input int v, input int sin,
                              input int pin, output int nv, output int ns);
        int sc, lo, hi;
        sc = 1 << lanes;
        lo = v % sc;
        hi = v / (256 / sc);
        nv = v;
        ns = 0;
        case (md)
            1: begin nv = (v * sc + sin) % 256;           ns = hi; end
            2: begin nv = v / sc + sin * (256 / sc);      ns = lo; end
            3: nv = pin;
            4: begin nv = (v * sc) % 256 + hi;            ns = hi; end
            5: begin nv = v / sc + lo * (256 / sc);       ns = lo; end
            6: begin nv = v / sc + ((v >= 128) ? (256 - 256 / sc) : 0); ns = lo; end
            7: nv = 0;
            default: ;
        endcase
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int lanes, sin, nv, ns;
            lanes = d + 1;
            sin   = t_ser % (1 << lanes);
            if (rst) begin
                m_par[d] = 0; m_ser[d] = 0; m_left[d] = 0;
                m_burst[d] = 0; m_done[d] = 0;
            end else if (m_done[d]) begin
                m_done[d] = 0;
            end else if (m_burst[d]) begin
                model_step(lanes, m_mode[d], m_par[d], sin, t_par, nv, ns);
                m_par[d] = nv; m_ser[d] = ns;
                m_left[d]--;
                if (m_left[d] == 0) begin
                    m_burst[d] = 0;
                    m_done[d]  = 1;
                end
            end else if (t_start != 0) begin
                m_mode[d] = t_mode;
                m_left[d] = t_cnt;
                if (t_cnt == 0) m_done[d] = 1;
                else            m_burst[d] = 1;
            end else if (t_en != 0) begin
                model_step(lanes, t_mode, m_par[d], sin, t_par, nv, ns);
                m_par[d] = nv; m_ser[d] = ns;
            end
        end
    endtask

    // Advance one clock, update the model, then compare just after the edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("par_l1",  32'(bus1.par_out), 32'(m_par[0]));
        chk("ser_l1",  32'(bus1.ser_out), 32'(m_ser[0]));
        chk("busy_l1", 32'(bus1.busy),    32'(m_burst[0]));
        chk("done_l1", 32'(bus1.done),    32'(m_done[0]));
        chk("par_l2",  32'(bus2.par_out), 32'(m_par[1]));
        chk("ser_l2",  32'(bus2.ser_out), 32'(m_ser[1]));
        chk("busy_l2", 32'(bus2.busy),    32'(m_burst[1]));
        chk("done_l2", 32'(bus2.done),    32'(m_done[1]));
    endtask

    task automatic op(input int md, input int par, input int ser);
        t_mode = md; t_par = par; t_ser = ser; t_en = 1; t_start = 0;
        tick();
        t_en = 0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_par", 32'(bus1.par_out), 32'h0);
        chk("rst_busy", 32'(bus1.busy), 32'h0);
        chk("rst_done", 32'(bus1.done), 32'h0);

        // LOAD 0xA5 then SHL ser_in=1 on the single-lane instance
        op(3, 'hA5, 0);
        op(1, 0, 1);
        chk("shl_par", 32'(bus1.par_out), 32'h4B);
        chk("shl_ser", 32'(bus1.ser_out), 32'h1);

        // Idle cycle keeps register and serial output
        tick();
        chk("idle_ser", 32'(bus1.ser_out), 32'h1);

        // LOAD 0x81, burst ROR x3 with en/start noise during RUN and DONE
        op(3, 'h81, 0);
        t_mode = 5; t_cnt = 3; t_start = 1;
        tick();
        chk("ror_busy0", 32'(bus1.busy), 32'h1);
        t_mode = 7; t_en = 1; t_cnt = 0;
        tick();
        chk("ror_e1", 32'(bus1.par_out), 32'hC0);
        tick();
        chk("ror_e2", 32'(bus1.par_out), 32'h60);
        tick();
        chk("ror_e3", 32'(bus1.par_out), 32'h30);
        chk("ror_ser", 32'(bus1.ser_out), 32'h0);
        chk("ror_done", 32'(bus1.done), 32'h1);
        chk("ror_busy3", 32'(bus1.busy), 32'h0);
        tick();
        t_en = 0; t_start = 0;
        chk("ror_after", 32'(bus1.par_out), 32'h30);
        chk("ror_done_off", 32'(bus1.done), 32'h0);

        // LOAD 0x90, ASR, then CLR
        op(3, 'h90, 0);
        op(6, 0, 1);
        chk("asr_par", 32'(bus1.par_out), 32'hC8);
        chk("asr_ser", 32'(bus1.ser_out), 32'h0);
        op(7, 0, 0);
        chk("clr_par", 32'(bus1.par_out), 32'h0);

        // Two-lane instance: LOAD 0xF0, SHR ser=01, ROL
        op(3, 'hF0, 0);
        op(2, 0, 1);
        chk("shr2_par", 32'(bus2.par_out), 32'h7C);
        chk("shr2_ser", 32'(bus2.ser_out), 32'h0);
        op(4, 0, 0);
        chk("rol2_par", 32'(bus2.par_out), 32'hF1);
        chk("rol2_ser", 32'(bus2.ser_out), 32'h1);

        // Zero-length burst, start together with en: no step happens
        t_mode = 1; t_cnt = 0; t_start = 1; t_en = 1; t_ser = 3;
        tick();
        t_start = 0; t_en = 0;
        chk("z_done", 32'(bus2.done), 32'h1);
        chk("z_busy", 32'(bus2.busy), 32'h0);
        chk("z_par", 32'(bus2.par_out), 32'hF1);
        tick();
        chk("z_done_off", 32'(bus2.done), 32'h0);

        // Reset after step 2 of a 5-step burst
        op(3, 'h3C, 0);
        t_mode = 1; t_cnt = 5; t_start = 1; t_ser = 1;
        tick();
        t_start = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_par", 32'(bus1.par_out), 32'h0);
        chk("mr_busy", 32'(bus1.busy), 32'h0);
        chk("mr_done", 32'(bus1.done), 32'h0);
        tick();
        chk("mr_no_done", 32'(bus1.done), 32'h0);
        // Fresh burst after the abort
        op(3, 'h01, 0);
        t_mode = 4; t_cnt = 2; t_start = 1;
        tick();
        t_start = 0;
        tick();
        tick();
        chk("fresh_par", 32'(bus1.par_out), 32'h04);
        chk("fresh_done", 32'(bus1.done), 32'h1);
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) < 2);
            t_mode  = int'($urandom_range(0, 7));
            t_en    = ($urandom_range(0, 99) < 45) ? 1 : 0;
            t_start = ($urandom_range(0, 99) < 12) ? 1 : 0;
            t_cnt   = int'($urandom_range(0, 7));
            t_par   = int'($urandom_range(0, 255));
            t_ser   = int'($urandom_range(0, 3));
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_universal_shift_reg
`default_nettype wire
